// File: rtl/mem_wrapper_access_resp.sv
// mem_wrapper_access_resp
// Wraps a memory macro that needs a fixed number of access cycles.
// A request is accepted in IDLE, the macro is driven for RD_WAIT/WR_WAIT
// cycles in ACCESS, and a single-cycle response is issued in RESP.
// Illegal operations skip the macro and respond with o_err=1.
//
// Handshake: i_op_valid is sampled only while IDLE (o_busy=0). A request is
// taken on the rising edge where IDLE and i_op_valid=1; o_valid then pulses
// for exactly one cycle with o_data/o_err. There is no backpressure on the
// response side and no queuing; requests seen while o_busy=1 are dropped.
module mem_wrapper_access_resp #(
  parameter int NBW_DATA = 8,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NBW_DATA-1:0] i_addr,
  input  logic [NBW_DATA-1:0] i_data,
  input  logic [3:0]          i_op,
  input  logic                i_region,
  input  logic                i_op_valid,
  output logic                o_valid,
  output logic [NBW_DATA-1:0] o_data,
  output logic                o_err,
  output logic                o_busy,
  output logic                o_mem_cs,
  output logic                o_mem_we,
  output logic                o_mem_ib,
  output logic [NBW_DATA-1:0] o_mem_addr,
  output logic [NBW_DATA-1:0] o_mem_wdata,
  input  logic [NBW_DATA-1:0] i_mem_rdata,
  output logic [1:0]          o_dbg_state
);

  localparam logic [3:0] OP_RD  = 4'h1;
  localparam logic [3:0] OP_WR  = 4'h2;
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                wr_q;
  logic [NBW_DATA-1:0] addr_q;
  logic [NBW_DATA-1:0] data_q;
  logic                region_q;

  logic op_legal;
  logic take_legal;
  logic take_illegal;
  logic last_access;

  assign op_legal     = (i_op == OP_RD) || (i_op == OP_WR);
  assign take_legal   = (state == ST_IDLE) && i_op_valid && op_legal;
  assign take_illegal = (state == ST_IDLE) && i_op_valid && !op_legal;
  // Counter of 0 is unreachable with legal waits, but treat it as final so
  // the FSM can never stall in ACCESS.
  assign last_access  = (state == ST_ACCESS) && (cnt <= 4'd1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_legal)        state_nxt = ST_ACCESS;
        else if (take_illegal) state_nxt = ST_RESP;
      end
      ST_ACCESS: if (last_access) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    o_valid     = (state == ST_RESP);
    o_busy      = (state != ST_IDLE);
    o_mem_cs    = (state == ST_ACCESS);
    o_mem_we    = (state == ST_ACCESS) && wr_q;
    o_dbg_state = state;
  end

  // Request capture; only legal ops update it, so macro-side outputs keep
  // their last values across idle periods and illegal requests.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      region_q <= 1'b0;
    end else if (take_legal) begin
      wr_q     <= (i_op == OP_WR);
      addr_q   <= i_addr;
      data_q   <= i_data;
      region_q <= i_region;
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = data_q;
  assign o_mem_ib    = region_q;

  // Wait counter: loaded on accept, counts down in ACCESS, saturates at 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= 4'd0;
    end else if (take_legal) begin
      cnt <= (i_op == OP_WR) ? WR_CNT : RD_CNT;
    end else if ((state == ST_ACCESS) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers, loaded on the edge entering RESP and held afterwards
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
      o_err  <= 1'b0;
    end else if (take_illegal) begin
      o_data <= '0;
      o_err  <= 1'b1;
    end else if (last_access) begin
      o_data <= wr_q ? data_q : i_mem_rdata;
      o_err  <= 1'b0;
    end
  end

endmodule

// File: doc/mem_wrapper_access_resp.md
MEM_WRAPPER_ACCESS_RESP -- requirements
Module: mem_wrapper_access_resp

Interface
REQ-001 Parameter NBW_DATA, default 8, sets the address, write-data and read-data width.
REQ-002 Parameter RD_WAIT, default 2, sets the macro read access cycles (legal 1..15).
REQ-003 Parameter WR_WAIT, default 4, sets the macro write access cycles (legal 1..15).
REQ-004 i_clk  in  1  is the single clock; all state changes on the rising edge.
REQ-005 i_rst_n  in  1  is the reset; it is asynchronous and active-low.
REQ-006 i_addr  in  NBW_DATA  is the request address.
REQ-007 i_data  in  NBW_DATA  is the request write data.
REQ-008 i_op  in  4  is the operation: 4'h1 READ, 4'h2 WRITE, all other codes illegal.
REQ-009 i_region  in  1  selects main memory (0) or information block (1).
REQ-010 i_op_valid  in  1  is the request strobe.
REQ-011 o_valid  out  1  is a one-cycle response pulse.
REQ-012 o_data  out  NBW_DATA  is the response data.
REQ-013 o_err  out  1  flags an illegal-op response and is valid with o_valid.
REQ-014 o_busy  out  1  is high whenever the FSM is not IDLE.
REQ-015 o_mem_cs, o_mem_we, o_mem_ib  out  1 each  are macro chip-select, write-enable and info-block select.
REQ-016 o_mem_addr, o_mem_wdata  out  NBW_DATA  are the macro address and write data; i_mem_rdata  in  NBW_DATA  is the macro read data.

Function
REQ-017 FSM states: IDLE, ACCESS and RESP; reset state is IDLE.
REQ-018 i_op_valid is sampled only in IDLE.
- i_op_valid=1 with a legal op: register addr, data, op and region, load the 4-bit wait counter with RD_WAIT or WR_WAIT, then go to ACCESS.
- i_op_valid=1 with an illegal op: go directly to RESP with no macro access.
REQ-019 In ACCESS:
- o_mem_cs=1, o_mem_we=1 for WRITE only.
- o_mem_ib, o_mem_addr and o_mem_wdata are driven from the registered request.
- The counter decrements each cycle; ACCESS lasts exactly WAIT cycles.
REQ-020 On the last ACCESS cycle (counter=1), i_mem_rdata is captured for READ; the FSM then goes to RESP.
REQ-021 RESP lasts one cycle with o_valid=1, then the FSM returns to IDLE unconditionally.
REQ-022 Response data in RESP:
- READ: o_data is the captured read data.
- WRITE: o_data is the written data.
- Illegal op: o_data is 0 and o_err=1.
- o_err=0 for every legal op.
REQ-023 o_data and o_err hold their values until the next RESP; o_valid is 0 outside RESP.
REQ-024 Latency from the capture edge to o_valid is WAIT+1 cycles for a legal op and 1 cycle for an illegal op.
REQ-025 Outside ACCESS, o_mem_cs and o_mem_we are 0; o_mem_addr, o_mem_wdata and o_mem_ib hold their last values.
REQ-026 The requester holds its request stable until o_valid and drops i_op_valid in the following cycle; back-to-back requests are accepted from the IDLE cycle after RESP.
REQ-027 Requests arriving while o_busy=1 are ignored; no queuing.
REQ-028 The wait counter saturates at 0 and never wraps.

Reset
REQ-029 Asserting i_rst_n=0 at any time, including mid-ACCESS, forces the FSM to IDLE and clears the counter.
REQ-030 Reset drives every output to 0 asynchronously; no o_valid pulse is issued for an aborted request.
REQ-031 After i_rst_n deasserts, the first request is accepted on the first rising edge with i_op_valid=1.

Verification
REQ-032 The bench shall cover these directed scenarios:
- READ addr 8'h3C, region 0, i_mem_rdata=8'hA5, RD_WAIT=2 -> o_mem_cs high 2 cycles with o_mem_we=0, then o_valid 3 cycles after capture with o_data=8'hA5 and o_err=0.
- WRITE addr 8'h10, data 8'h5A, region 1, WR_WAIT=4 -> o_mem_cs=o_mem_we=o_mem_ib=1 for 4 cycles, o_mem_wdata=8'h5A, then o_valid with o_data=8'h5A.
- i_op=4'h7 -> o_valid 1 cycle after capture, o_data=0, o_err=1, o_mem_cs never asserted.
- A second request raised during ACCESS -> ignored; exactly one o_valid pulse is seen.
- Back-to-back READ then WRITE -> WRITE is captured in the IDLE cycle after RESP; both responses are correct.
- i_rst_n pulled low in the middle of a WRITE -> all outputs go to 0 immediately, no o_valid is seen, and a new READ after release completes normally.
